// File: rtl/aclk_pkg.sv
// Shared key codes and keypad position map for the alarm-clock keypad front end.
package aclk_pkg;

  localparam logic [3:0] NOKEY    = 4'd10;
  localparam logic [3:0] KEY_STAR = 4'd11;
  localparam logic [3:0] KEY_HASH = 4'd12;

  // Index r*3+c; row-major layout 1 2 3 / 4 5 6 / 7 8 9 / * 0 #
  localparam logic [11:0][3:0] KEY_MAP = {
    KEY_HASH, 4'd0, KEY_STAR,
    4'd9, 4'd8, 4'd7,
    4'd6, 4'd5, 4'd4,
    4'd3, 4'd2, 4'd1
  };

  typedef enum logic [1:0] {Col0, Col1, Col2} col_state_e;

  // Exactly one pressed position yields its code; none or several yield NOKEY.
  function automatic logic [3:0] frame_code(input logic [11:0] press);
    logic [3:0]  code;
    int unsigned hits;
    code = NOKEY;
    hits = 0;
    for (int i = 0; i < 12; i++) begin
      if (press[i]) begin
        hits++;
        code = KEY_MAP[i];
      end
    end
    return (hits == 1) ? code : NOKEY;
  endfunction

endpackage

// File: rtl/aclk_debounce.sv
// Frame-level debouncer: a frame code must repeat before it becomes the stable code.
module aclk_debounce
  import aclk_pkg::*;
#(
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_end,
  input  logic [3:0] frame_code,
  output logic [3:0] stable
);

  localparam int unsigned CntW = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
  localparam logic [CntW-1:0] MatchMax = CntW'(DEBOUNCE_SCANS - 1);

  logic [3:0]      cand_q, cand_d;
  logic [CntW-1:0] match_q, match_d;
  logic [3:0]      stable_q, stable_d;

  always_comb begin
    cand_d   = cand_q;
    match_d  = match_q;
    stable_d = stable_q;
    if (frame_end) begin
      if (frame_code == cand_q) begin
        if (match_q < MatchMax) begin
          match_d = match_q + 1'b1;
        end else begin
          stable_d = cand_q;
        end
      end else begin
        cand_d  = frame_code;
        match_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cand_q   <= NOKEY;
      match_q  <= '0;
      stable_q <= NOKEY;
    end else begin
      cand_q   <= cand_d;
      match_q  <= match_d;
      stable_q <= stable_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/aclk_keyscan.sv
// 4x3 keypad scanner with row synchroniser, ghost rejection and debounce.
// Optional key_strobe output is enabled by defining ACLK_KEYSCAN_STROBE_EN.
module aclk_keyscan
  import aclk_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 250,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [2:0] col,
  output logic [3:0] key,
  output logic       alarm_button,
  output logic       time_button
`ifdef ACLK_KEYSCAN_STROBE_EN
  ,
  output logic       key_strobe
`endif
);

  localparam int unsigned DwellW = $clog2(SCAN_DIV);
  localparam logic [DwellW-1:0] DwellMax = DwellW'(SCAN_DIV - 1);

  logic [3:0]        row_meta_q, row_s_q;
  logic [DwellW-1:0] dwell_q, dwell_d;
  col_state_e        col_idx_q, col_idx_d;
  logic [2:0]        col_q, col_d;
  logic [11:0]       press_q, press_d;
  logic [11:0]       col_hits;
  int unsigned       col_num;
  logic              frame_end;
  logic [3:0]        code;
  logic [3:0]        stable;
  logic [3:0]        key_q, key_d;
  logic              alarm_q, time_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_meta_q <= 4'hF;
      row_s_q    <= 4'hF;
    end else begin
      row_meta_q <= row;
      row_s_q    <= row_meta_q;
    end
  end

  always_comb begin
    dwell_d   = dwell_q + 1'b1;
    col_idx_d = col_idx_q;
    col_d     = col_q;
    press_d   = press_q;
    frame_end = 1'b0;
    col_hits  = '0;
    col_num   = (col_idx_q == Col1) ? 1 : (col_idx_q == Col2) ? 2 : 0;
    for (int r = 0; r < 4; r++) begin
      col_hits[r*3 + col_num] = ~row_s_q[r];
    end
    if (dwell_q == DwellMax) begin
      dwell_d = '0;
      unique case (col_idx_q)
        Col0: begin
          // First sample of a frame starts a fresh press vector.
          press_d   = col_hits;
          col_idx_d = Col1;
          col_d     = 3'b101;
        end
        Col1: begin
          press_d   = press_q | col_hits;
          col_idx_d = Col2;
          col_d     = 3'b011;
        end
        Col2: begin
          press_d   = press_q | col_hits;
          frame_end = 1'b1;
          col_idx_d = Col0;
          col_d     = 3'b110;
        end
        default: begin
          press_d   = '0;
          col_idx_d = Col0;
          col_d     = 3'b110;
        end
      endcase
    end
  end

  assign code = frame_code(press_d);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dwell_q   <= '0;
      col_idx_q <= Col0;
      col_q     <= 3'b110;
      press_q   <= '0;
    end else begin
      dwell_q   <= dwell_d;
      col_idx_q <= col_idx_d;
      col_q     <= col_d;
      press_q   <= press_d;
    end
  end

  aclk_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk       (clk),
    .reset     (reset),
    .frame_end (frame_end),
    .frame_code(code),
    .stable    (stable)
  );

  always_comb begin
    key_d = (stable <= 4'd9) ? stable : NOKEY;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_q   <= NOKEY;
      alarm_q <= 1'b0;
      time_q  <= 1'b0;
    end else begin
      key_q   <= key_d;
      alarm_q <= (stable == KEY_STAR);
      time_q  <= (stable == KEY_HASH);
    end
  end

  assign col          = col_q;
  assign key          = key_q;
  assign alarm_button = alarm_q;
  assign time_button  = time_q;

`ifdef ACLK_KEYSCAN_STROBE_EN
  logic strobe_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= (key_d != key_q) && (key_d != NOKEY);
    end
  end

  assign key_strobe = strobe_q;
`endif

endmodule
